// File: rtl/rf_writeback_pkg.sv
// Core-wide register-file types shared by writeback, the register file and decode.
package rf_writeback_pkg;
    localparam int CORE_DW  = 12;
    localparam int CORE_RFW = 2;

    typedef logic [CORE_RFW-1:0] reg_addr_t;
    typedef logic [CORE_DW-1:0]  data_word_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding load results until the write port is free.
module rf_wb_fifo #(
    parameter int W  = 14,
    parameter int QD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         din,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(QD):0]  count
);
    localparam int PW = $clog2(QD);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [QD];
    logic [W-1:0]  mem_d [QD];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(QD));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QD; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: rtl/rf_writeback.sv
// Register-file write-port arbiter: ALU results first, buffered loads otherwise,
// with a per-register pending scoreboard for RAW stalls.
module rf_writeback
    import rf_writeback_pkg::*;
#(
    parameter int DW  = CORE_DW,
    parameter int RFW = CORE_RFW,
    parameter int QD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [RFW-1:0]      issue_rd,
    input  logic                alu_valid,
    input  logic [RFW-1:0]      alu_rd,
    input  logic [DW-1:0]       alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [RFW-1:0]      mem_rd,
    input  logic [DW-1:0]       mem_data,
    output logic                rf_we,
    output logic [RFW-1:0]      rf_wr_address,
    output logic [DW-1:0]       rf_wr_data,
    output logic [2**RFW-1:0]   pending,
    output logic                busy
);
    localparam int NREG = 2**RFW;
    localparam int EW   = RFW + DW;

    logic [EW-1:0]        fifo_head;
    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [$clog2(QD):0]  fifo_count;

    logic                 sel_valid;
    logic [RFW-1:0]       sel_rd;
    logic [DW-1:0]        sel_data;

    logic                 rf_we_q, rf_we_d;
    logic [RFW-1:0]       rf_wr_address_q, rf_wr_address_d;
    logic [DW-1:0]        rf_wr_data_q, rf_wr_data_d;
    logic [NREG-1:0]      pending_q, pending_d;

    rf_wb_fifo #(.W(EW), .QD(QD)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mem_valid),
        .pop   (fifo_pop),
        .din   ({mem_rd, mem_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        fifo_pop  = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            sel_valid = 1'b1;
            {sel_rd, sel_data} = fifo_head;
        end

        // r0 writes are consumed (FIFO still pops) but never reach the register file.
        rf_we_d         = sel_valid && (sel_rd != RFW'(REG_ZERO));
        rf_wr_address_d = rf_we_d ? sel_rd   : rf_wr_address_q;
        rf_wr_data_d    = rf_we_d ? sel_data : rf_wr_data_q;

        // Clear before set so a same-edge reissue of the register stays pending.
        pending_d = pending_q;
        if (sel_valid) pending_d[sel_rd] = 1'b0;
        if (issue_valid) pending_d[issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q         <= 1'b0;
            rf_wr_address_q <= '0;
            rf_wr_data_q    <= '0;
            pending_q       <= '0;
        end else begin
            rf_we_q         <= rf_we_d;
            rf_wr_address_q <= rf_wr_address_d;
            rf_wr_data_q    <= rf_wr_data_d;
            pending_q       <= pending_d;
        end
    end

    assign mem_ready     = !fifo_full;
    assign busy          = (fifo_count != '0) || rf_we_q;
    assign rf_we         = rf_we_q;
    assign rf_wr_address = rf_wr_address_q;
    assign rf_wr_data    = rf_wr_data_q;
    assign pending       = pending_q;
endmodule

// File: tb/tb_rf_writeback.sv
// Directed vector bench for rf_writeback.
module tb_rf_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, alu_valid, mem_valid;
    logic [1:0]  issue_rd, alu_rd, mem_rd;
    logic [11:0] alu_data, mem_data;
    logic        mem_ready, rf_we, busy;
    logic [1:0]  rf_wr_address;
    logic [11:0] rf_wr_data;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_writeback #(.DW(12), .RFW(2), .QD(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .rf_we         (rf_we),
        .rf_wr_address (rf_wr_address),
        .rf_wr_data    (rf_wr_data),
        .pending       (pending),
        .busy          (busy)
    );

    typedef struct {
        logic        iv;  logic [1:0] ird;
        logic        av;  logic [1:0] ard; logic [11:0] ad;
        logic        mv;  logic [1:0] mrd; logic [11:0] md;
        logic        we;  logic [1:0] wa;  logic [11:0] wd;
        logic [3:0]  pend; logic rdy; logic bsy;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] ird, input logic av, input logic [1:0] ard,
                         input logic [11:0] ad, input logic mv, input logic [1:0] mrd, input logic [11:0] md);
        issue_valid = iv; issue_rd = ird;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [1:0] wa, input logic [11:0] wd,
                             input logic [3:0] pend, input logic rdy, input logic bsy);
        check({tag, "_we"},   32'(rf_we), 32'(we));
        check({tag, "_addr"}, 32'(rf_wr_address), 32'(wa));
        check({tag, "_data"}, 32'(rf_wr_data), 32'(wd));
        check({tag, "_pend"}, 32'(pending), 32'(pend));
        check({tag, "_rdy"},  32'(mem_ready), 32'(rdy));
        check({tag, "_busy"}, 32'(busy), 32'(bsy));
    endtask

    initial begin
        //            iv ird  av ard ad       mv mrd md        we wa  wd       pend     rdy bsy
        tbl[0]  = '{0, 0, 1, 2, 12'h5A5, 0, 0, 12'h000, 1, 2, 12'h5A5, 4'b0000, 1, 1};
        tbl[1]  = '{0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 2, 12'h5A5, 4'b0000, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 12'h000, 1, 3, 12'h123, 0, 2, 12'h5A5, 4'b0000, 1, 1};
        tbl[3]  = '{0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 1, 3, 12'h123, 4'b0000, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 3, 12'h123, 4'b0000, 1, 0};
        tbl[5]  = '{0, 0, 1, 0, 12'hFFF, 0, 0, 12'h000, 0, 3, 12'h123, 4'b0000, 1, 0};
        tbl[6]  = '{1, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 3, 12'h123, 4'b0000, 1, 0};
        tbl[7]  = '{1, 1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 3, 12'h123, 4'b0010, 1, 0};
        tbl[8]  = '{1, 1, 1, 1, 12'h111, 0, 0, 12'h000, 1, 1, 12'h111, 4'b0010, 1, 1};
        tbl[9]  = '{0, 0, 1, 1, 12'h222, 0, 0, 12'h000, 1, 1, 12'h222, 4'b0000, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 12'h000, 1, 0, 12'hABC, 0, 1, 12'h222, 4'b0000, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 1, 12'h222, 4'b0000, 1, 0};
        tbl[12] = '{1, 3, 1, 2, 12'h0F0, 0, 0, 12'h000, 1, 2, 12'h0F0, 4'b1000, 1, 1};
        tbl[13] = '{1, 2, 1, 3, 12'h333, 0, 0, 12'h000, 1, 3, 12'h333, 4'b0100, 1, 1};
        tbl[14] = '{0, 0, 1, 2, 12'h444, 0, 0, 12'h000, 1, 2, 12'h444, 4'b0000, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 2, 12'h444, 4'b0000, 1, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check_out("reset", 0, 0, 0, 4'b0000, 1, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].iv, tbl[i].ird, tbl[i].av, tbl[i].ard, tbl[i].ad,
                  tbl[i].mv, tbl[i].mrd, tbl[i].md);
            step();
            check_out($sformatf("v%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd,
                      tbl[i].pend, tbl[i].rdy, tbl[i].bsy);
        end

        // Backpressure: loads queue behind three ALU writes, then drain in order.
        drive(0, 0, 1, 1, 12'hA01, 1, 1, 12'h011); step();
        check_out("bp1", 1, 1, 12'hA01, 4'b0000, 1, 1);
        drive(0, 0, 1, 2, 12'hA02, 1, 2, 12'h022); step();
        check_out("bp2", 1, 2, 12'hA02, 4'b0000, 0, 1);
        drive(0, 0, 1, 3, 12'hA03, 1, 3, 12'h0EE); step();
        check_out("bp3", 1, 3, 12'hA03, 4'b0000, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        check_out("bp4", 1, 1, 12'h011, 4'b0000, 1, 1);
        step();
        check_out("bp5", 1, 2, 12'h022, 4'b0000, 1, 1);
        step();
        check_out("bp6", 0, 2, 12'h022, 4'b0000, 1, 0);

        // Reset mid-operation with a full FIFO and pending=1110.
        drive(1, 1, 1, 3, 12'h100, 1, 2, 12'h055); step();
        drive(1, 2, 1, 3, 12'h101, 1, 3, 12'h066); step();
        drive(1, 3, 1, 0, 12'h102, 0, 0, 0); step();
        check_out("pre_rst", 0, 3, 12'h101, 4'b1110, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_out("mid_rst", 0, 0, 0, 4'b0000, 1, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("post_rst%0d", i), 0, 0, 0, 4'b0000, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side controller for the core register file.
- Merges ALU results and memory-load results into the single register-file write port.
- Buffers load results in a small FIFO.
- Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file's we/wr_address/wr_data inputs.

Parameters:
- DW, 12, data width of one register.
- RFW, 2, register address width; the register file holds 2**RFW registers.
- QD, 2, depth of the memory-result FIFO; must be a power of two, at least 2.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_rd  in  RFW  destination register of the issuing instruction.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  RFW  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  FIFO can accept a load result (registered, equals !full).
- mem_rd  in  RFW  load destination register.
- mem_data  in  DW  load data.
- rf_we  out  1  register-file write enable (registered).
- rf_wr_address  out  RFW  register-file write address (registered).
- rf_wr_data  out  DW  register-file write data (registered).
- pending  out  2**RFW  bit i set means a write to register i is outstanding.
- busy  out  1  FIFO non-empty, or rf_we high.

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO emptied; pointers and count cleared.
  - pending = 0, rf_we = 0, rf_wr_address = 0, rf_wr_data = 0.
  - mem_ready = 1, busy = 0.
  - Reset mid-operation drops all buffered results without writing them.
- Write selection, evaluated each posedge:
  - If alu_valid: write the ALU result.
  - Else if FIFO non-empty: pop the head and write it.
  - Else: rf_we = 0 next cycle.
  - ALU has strict priority. A FIFO entry can wait indefinitely under back-to-back ALU traffic; no starvation guard.
- Latency:
  - ALU result sampled at edge N appears on rf_* after edge N.
  - The register file commits on the following negedge, so it is readable in cycle N+1.
  - Load pushed at edge N is eligible to pop at edge N+1 at the earliest, so it appears on rf_* after N+1.
- FIFO handshake:
  - Push when mem_valid && mem_ready.
  - mem_ready is computed from the registered count only; a pop in the same cycle does not raise it.
  - Push and pop in the same edge keep count unchanged.
  - Pointers are QD-wrapping; count has width clog2(QD)+1.
  - mem_valid while mem_ready = 0: ignored. The producer must hold the result.
- Register zero (hardwired to zero):
  - A write selected for rd == 0 drives rf_we = 0, but the FIFO still pops.
  - issue with issue_rd == 0 never sets a pending bit; pending[0] is always 0.
- Scoreboard:
  - issue_valid sets pending[issue_rd] at the edge.
  - A selected write to rd clears pending[rd] at the same edge.
  - Set and clear of the same register on the same edge: set wins (newer instruction).
  - A write to a register whose pending bit is 0 is still performed; no error.
- Output encoding:
  - rf_wr_address and rf_wr_data hold their last value when rf_we = 0.
  - No X on outputs after reset.

Decomposition:
- Shared core package holds: DW, RFW, the register-zero address constant, and the reg-address and data-word typedefs, shared with the register file and decode.
- One natural sub-module: rf_wb_fifo, a synchronous QD-deep FIFO (push/pop/full/empty/count, asynchronous reset).
- Selection, r0 masking, and scoreboard stay in rf_writeback.

Test Plan:
- ALU write: alu_valid, rd=2, data=0x5A5 at edge N -> after N rf_we=1, addr=2, data=0x5A5. After N+1 rf_we=0 and addresses/data hold.
- Load through empty FIFO: mem rd=3, data=0x123 at edge N, no ALU -> after N+1 rf_we=1, addr=3, data=0x123. mem_ready stays 1.
- Priority and backpressure:
  - Stimulus: push loads to r1 then r2 (FIFO full); keep alu_valid for 3 cycles.
  - Expected: mem_ready=0 while full; the three ALU writes land first; then r1, then r2. busy falls after the last write.
- Register zero:
  - ALU rd=0 data=0xFFF -> rf_we stays 0.
  - issue_rd=0 -> pending stays 0.
  - Load to r0 in the FIFO -> pops with no write.
- Scoreboard:
  - issue rd=1 -> pending=0b0010.
  - ALU write rd=1 together with issue rd=1 on the same edge -> pending[1] remains 1.
  - Next ALU write to r1 -> pending=0.
- Reset mid-operation: FIFO holding 2 entries, pending=0b1110, rst pulsed between edges -> outputs zero immediately, mem_ready=1, no writes after release.
